// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Stall/flush controller for an in-order pipeline of NUM_STAGES stages.
// Stage 0 is fetch, and higher indices hold older instructions.
// It merges three kinds of request: level stall requests, one counted
// multi-cycle stall and redirect flushes. From these it drives the hold,
// bubble and invalidate enables of every pipeline register.
//
// Optional feature: define HAZARD_PERF_CNT_EN to add three 32-bit
// saturating performance counters, each with its own output port.
//
// Ports:
//   clk, reset_n      rising-edge clock, asynchronous active-low reset
//   stall_req         per-stage level stall request
//   timed_req/_stage/_cycles   counted stall request, owner stage, length
//   timed_ack         request accepted this cycle (only while idle)
//   timed_done        one-cycle pulse after the last counted stall cycle
//   flush_req/_src    redirect pulse and the stage that resolved it
//   stall_stage       hold pipeline register i
//   bubble_stage      load a NOP into stage i
//   flush_stage       invalidate stage i
//   busy              counted stall or flush hold in progress
//   stall_cycle_cnt, flush_cnt, timed_abort_cnt   (HAZARD_PERF_CNT_EN only)
module pipe_hazard_ctrl #(
    parameter int NUM_STAGES   = 5,
    parameter int CNT_W        = 4,
    parameter int FLUSH_CYCLES = 1,
    parameter int IDX_W        = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_STAGES-1:0] stall_req,
    input  logic                  timed_req,
    input  logic [IDX_W-1:0]      timed_stage,
    input  logic [CNT_W-1:0]      timed_cycles,
    output logic                  timed_ack,
    output logic                  timed_done,
    input  logic                  flush_req,
    input  logic [IDX_W-1:0]      flush_src,
    output logic [NUM_STAGES-1:0] stall_stage,
    output logic [NUM_STAGES-1:0] bubble_stage,
    output logic [NUM_STAGES-1:0] flush_stage,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]           stall_cycle_cnt,
    output logic [31:0]           flush_cnt,
    output logic [31:0]           timed_abort_cnt,
`endif
    output logic                  busy
);

    localparam int          HOLD_W = 3;
    localparam logic [31:0] NS     = NUM_STAGES;

    typedef enum logic {IDLE, TIMED} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        t_stage;
    logic [NUM_STAGES-1:0]   hold_mask;
    logic [HOLD_W-1:0]       hold_cnt;

    logic [31:0]             src_ext;
    logic [31:0]             req_stage_ext;
    logic [31:0]             t_stage_ext;
    logic                    flush_valid;
    logic                    hold_active;
    logic                    timed_start;
    logic                    timed_abort;
    logic                    reach;
    logic [NUM_STAGES-1:0]   new_mask;
    logic [NUM_STAGES-1:0]   flush_comb;
    logic [NUM_STAGES-1:0]   src_mask;
    logic [NUM_STAGES-1:0]   stall_raw;
    logic [NUM_STAGES-1:0]   bubble_raw;

    assign src_ext       = 32'(flush_src);
    assign req_stage_ext = 32'(timed_stage);
    assign t_stage_ext   = 32'(t_stage);

    // A redirect from stage 0 or from a non-existent stage has nothing younger
    // to kill, so it is dropped completely.
    assign flush_valid = flush_req && (src_ext != 32'd0) && (src_ext < NS);
    assign hold_active = (hold_cnt != '0);

    // Every stage younger than the redirecting stage is invalidated now.
    // A hold that is still running adds its registered mask.
    always_comb begin
        new_mask = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            new_mask[i] = flush_valid && (32'(i) < src_ext);
        end
    end

    assign flush_comb = new_mask | (hold_active ? hold_mask : '0);

    // A counted stall whose owner is being flushed has no instruction left to
    // wait for. A request for a stage that the same redirect kills is also
    // discarded.
    assign timed_abort = (state == TIMED) && flush_valid && (t_stage_ext < src_ext);
    assign timed_start = (state == IDLE) && timed_req && (timed_cycles != '0) &&
                         (req_stage_ext < NS) &&
                         !(flush_valid && (req_stage_ext < src_ext));

    // The counted stall owner is one more level stall source.
    always_comb begin
        src_mask = stall_req;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if ((state == TIMED) && (t_stage_ext == 32'(i))) begin
                src_mask[i] = 1'b1;
            end
        end
    end

    // Stall every stage at or below the oldest stalling stage. To do this, an
    // OR is carried from the oldest stage down towards fetch.
    always_comb begin
        reach     = 1'b0;
        stall_raw = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            reach        = reach | src_mask[i];
            stall_raw[i] = reach;
        end
    end

    // The stage just above the stalled block keeps moving, so it receives a
    // bubble. That stage sits at the single 1-to-0 edge of stall_raw.
    always_comb begin
        bubble_raw = '0;
        for (int i = 1; i < NUM_STAGES; i++) begin
            bubble_raw[i] = stall_raw[i-1] & ~stall_raw[i];
        end
    end

    // A flushed stage must advance to accept the redirect, so the flush mask
    // overrides stall and bubble. All outputs are gated by reset_n. This makes
    // them drop to 0 as soon as reset is asserted, even though some of them
    // are computed from live inputs.
    assign flush_stage  = reset_n ? flush_comb : '0;
    assign stall_stage  = reset_n ? (stall_raw & ~flush_comb) : '0;
    assign bubble_stage = reset_n ? (bubble_raw & ~flush_comb) : '0;
    assign timed_ack    = reset_n && (state == IDLE) && timed_req;
    assign busy         = (state == TIMED) || hold_active;

    // Counted stall FSM and flush hold.
    // Loading cnt with N gives exactly N stall cycles. timed_done is raised on
    // the edge that leaves TIMED normally, so it appears in the first cycle
    // after the last stalled cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            t_stage    <= '0;
            timed_done <= 1'b0;
            hold_mask  <= '0;
            hold_cnt   <= '0;
        end else begin
            timed_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (timed_start) begin
                        state   <= TIMED;
                        cnt     <= timed_cycles;
                        t_stage <= timed_stage;
                    end
                end
                TIMED: begin
                    if (timed_abort) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(1)) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        timed_done <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            // A new redirect restarts the hold with the merged mask. When
            // FLUSH_CYCLES is 1 the counter is loaded with 0, so no hold happens.
            if (flush_valid) begin
                hold_mask <= flush_comb;
                hold_cnt  <= HOLD_W'(FLUSH_CYCLES - 1);
            end else if (hold_active) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
                if (hold_cnt == HOLD_W'(1)) begin
                    hold_mask <= '0;
                end
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Performance counters saturate at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycle_cnt <= '0;
            flush_cnt       <= '0;
            timed_abort_cnt <= '0;
        end else begin
            if ((stall_stage != '0) && (stall_cycle_cnt != '1)) begin
                stall_cycle_cnt <= stall_cycle_cnt + 32'd1;
            end
            if (flush_valid && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
            if (timed_abort && (timed_abort_cnt != '1)) begin
                timed_abort_cnt <= timed_abort_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl with a 5-stage pipeline, CNT_W=4 and a
// 3-cycle flush hold. Directed scenarios are followed by a randomized run.
// All outputs are checked against a cycle-level model that tracks the
// remaining stall cycles and flush hold.
module tb_pipe_hazard_ctrl;

    localparam int N  = 5;
    localparam int CW = 4;
    localparam int FC = 3;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  stall_req;
    logic          timed_req;
    logic [IW-1:0] timed_stage;
    logic [CW-1:0] timed_cycles;
    logic          flush_req;
    logic [IW-1:0] flush_src;
    logic          timed_ack;
    logic          timed_done;
    logic          busy;
    logic [N-1:0]  stall_stage;
    logic [N-1:0]  bubble_stage;
    logic [N-1:0]  flush_stage;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]   stall_cycle_cnt;
    logic [31:0]   flush_cnt;
    logic [31:0]   timed_abort_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model state: remaining counted stall cycles (0 = idle), the
    // owner stage, the pending done pulse, the flush hold and event totals.
    int m_left, m_owner, m_hold_left, m_hold_mask;
    int m_stall_cycles, m_flushes, m_aborts;
    bit m_done;

    logic [3*N+2:0] exp_vec;
    logic [3*N+2:0] obs_vec;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .NUM_STAGES  (N),
        .CNT_W       (CW),
        .FLUSH_CYCLES(FC),
        .IDX_W       (IW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall_req      (stall_req),
        .timed_req      (timed_req),
        .timed_stage    (timed_stage),
        .timed_cycles   (timed_cycles),
        .timed_ack      (timed_ack),
        .timed_done     (timed_done),
        .flush_req      (flush_req),
        .flush_src      (flush_src),
        .stall_stage    (stall_stage),
        .bubble_stage   (bubble_stage),
        .flush_stage    (flush_stage),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycle_cnt(stall_cycle_cnt),
        .flush_cnt      (flush_cnt),
        .timed_abort_cnt(timed_abort_cnt),
`endif
        .busy           (busy)
    );

    assign obs_vec = {stall_stage, bubble_stage, flush_stage, timed_ack, timed_done, busy};

    // Mask of stages killed by the redirect presented this cycle.
    function automatic int new_flush_mask();
        int s = int'(flush_src);
        if (!flush_req || s == 0 || s >= N) return 0;
        return (1 << s) - 1;
    endfunction

    function automatic int held_mask();
        return (m_hold_left > 0) ? m_hold_mask : 0;
    endfunction

    // Index of the oldest stage requesting a stall, or -1 if none.
    function automatic int top_source();
        int h = -1;
        for (int k = 0; k < N; k++) if (stall_req[k]) h = k;
        if (m_left > 0 && m_owner > h) h = m_owner;
        return h;
    endfunction

    task automatic model_reset();
        m_left = 0; m_owner = 0; m_hold_left = 0; m_hold_mask = 0; m_done = 0;
        m_stall_cycles = 0; m_flushes = 0; m_aborts = 0;
    endtask

    task automatic model_outputs();
        int h, fl, st, bu;
        fl = new_flush_mask() | held_mask();
        h  = top_source();
        st = (h >= 0) ? ((1 << (h + 1)) - 1) : 0;
        bu = (h >= 0 && h < N - 1) ? (1 << (h + 1)) : 0;
        st = st & ~fl;
        bu = bu & ~fl;
        if (!reset_n) exp_vec = '0;
        else exp_vec = {N'(st), N'(bu), N'(fl), 1'(timed_req && m_left == 0),
                        1'(m_done), 1'(m_left > 0 || m_hold_left > 0)};
    endtask

    task automatic model_advance();
        int s, nm, fl, ts, h;
        bit fv;
        s  = int'(flush_src);
        nm = new_flush_mask();
        fv = (nm != 0);
        fl = nm | held_mask();
        h  = top_source();
        if (h >= 0 && ((((1 << (h + 1)) - 1) & ~fl) != 0)) m_stall_cycles++;
        m_done = 0;
        ts = int'(timed_stage);
        if (m_left > 0) begin
            if (fv && m_owner < s) begin
                m_left = 0;
                m_aborts++;
            end else begin
                m_left--;
                if (m_left == 0) m_done = 1;
            end
        end else if (timed_req && timed_cycles != 0 && ts < N && !(fv && ts < s)) begin
            m_left  = int'(timed_cycles);
            m_owner = ts;
        end
        if (fv) begin
            m_flushes++;
            m_hold_mask = fl;
            m_hold_left = FC - 1;
        end else if (m_hold_left > 0) begin
            m_hold_left--;
        end
    endtask

    task automatic drive(input logic [N-1:0] sr, input logic tr, input int ts,
                         input int tc, input logic fr, input int fs);
        stall_req    = sr;
        timed_req    = tr;
        timed_stage  = IW'(ts);
        timed_cycles = CW'(tc);
        flush_req    = fr;
        flush_src    = IW'(fs);
    endtask

    // Outputs are sampled on the falling edge. Inputs change 1 time unit
    // after the rising edge.
    task automatic settle();
        @(negedge clk);
        model_outputs();
    endtask

    task automatic advance();
        @(posedge clk);
        if (reset_n) model_advance();
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive('0, 1'b0, 0, 0, 1'b0, 0);
        model_reset();
        #2;
        if (obs_vec !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", obs_vec, {(3*N+3){1'b0}});
        end
        n_cmp++;
        timed_req = 1'b1;
        #1;
        if (timed_ack !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ack: got %b expected 0", timed_ack);
        end
        n_cmp++;
        @(negedge clk);
        reset_n = 1'b1;
        drive('0, 1'b0, 0, 0, 1'b0, 0);
        advance();
    endtask

    task automatic test_level_stall();
        drive(5'b00010, 1'b0, 0, 0, 1'b0, 0);
        settle();
        if ({stall_stage, bubble_stage, flush_stage} !== {5'b00011, 5'b00100, 5'b00000}) begin
            n_fail++;
            $display("[TB] FAIL level_stall_directed: got %b expected %b",
                     {stall_stage, bubble_stage, flush_stage}, {5'b00011, 5'b00100, 5'b00000});
        end
        n_cmp++;
        advance();
        for (int i = 0; i < 8; i++) begin
            drive(N'($urandom), 1'b0, 0, 0, 1'b0, 0);
            settle();
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL level_stall cycle %0d: got %b expected %b", cyc, obs_vec, exp_vec);
            end
            n_cmp++;
            advance();
        end
    endtask

    task automatic test_timed();
        logic [3*N+2:0] want [5];
        want[0] = {5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b0, 1'b0};
        want[1] = {5'b00111, 5'b01000, 5'b00000, 1'b0, 1'b0, 1'b1};
        want[2] = want[1];
        want[3] = want[1];
        want[4] = {5'b00000, 5'b00000, 5'b00000, 1'b0, 1'b1, 1'b0};
        drive('0, 1'b1, 2, 3, 1'b0, 0);
        for (int c = 0; c < 5; c++) begin
            settle();
            if (obs_vec !== want[c] || obs_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL timed_stall step %0d: got %b expected %b (model %b)",
                         c, obs_vec, want[c], exp_vec);
            end
            n_cmp++;
            advance();
            drive('0, 1'b0, 0, 0, 1'b0, 0);
        end
    endtask

    task automatic test_flush_abort();
        drive('0, 1'b1, 2, 5, 1'b0, 0);
        advance();
        drive('0, 1'b0, 0, 0, 1'b0, 0);
        advance();
        drive('0, 1'b0, 0, 0, 1'b1, 3);
        settle();
        if (flush_stage !== 5'b00111 || stall_stage !== 5'b00000 || obs_vec !== exp_vec) begin
            n_fail++;
            $display("[TB] FAIL flush_abort: got flush=%b stall=%b expected flush=00111 stall=00000 (vec %b model %b)",
                     flush_stage, stall_stage, obs_vec, exp_vec);
        end
        n_cmp++;
        advance();
        // A zero-length request is acked only when the FSM is idle again.
        drive('0, 1'b1, 0, 0, 1'b0, 0);
        settle();
        if (timed_ack !== 1'b1 || timed_done !== 1'b0 || obs_vec !== exp_vec) begin
            n_fail++;
            $display("[TB] FAIL abort_idle: got ack=%b done=%b expected ack=1 done=0 (vec %b model %b)",
                     timed_ack, timed_done, obs_vec, exp_vec);
        end
        n_cmp++;
        advance();
        drive('0, 1'b0, 0, 0, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            settle();
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL abort_after cycle %0d: got %b expected %b", cyc, obs_vec, exp_vec);
            end
            n_cmp++;
            advance();
        end
    endtask

    task automatic test_flush_hold();
        logic [N-1:0] want_fl [6];
        logic         want_busy [6];
        want_fl   = '{5'b00011, 5'b00011, 5'b01111, 5'b01111, 5'b01111, 5'b00000};
        want_busy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int c = 0; c < 6; c++) begin
            if (c == 0)      drive('0, 1'b0, 0, 0, 1'b1, 2);
            else if (c == 2) drive('0, 1'b0, 0, 0, 1'b1, 4);
            else             drive('0, 1'b0, 0, 0, 1'b0, 0);
            settle();
            if (flush_stage !== want_fl[c] || busy !== want_busy[c] || obs_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL flush_hold step %0d: got flush=%b busy=%b expected flush=%b busy=%b (model %b)",
                         c, flush_stage, busy, want_fl[c], want_busy[c], exp_vec);
            end
            n_cmp++;
            advance();
        end
    endtask

    task automatic test_flush_vs_stall();
        drive(5'b00100, 1'b0, 0, 0, 1'b1, 2);
        settle();
        if ({flush_stage, stall_stage, bubble_stage} !== {5'b00011, 5'b00100, 5'b01000} ||
            obs_vec !== exp_vec) begin
            n_fail++;
            $display("[TB] FAIL flush_vs_stall: got f/s/b=%b expected %b (model %b)",
                     {flush_stage, stall_stage, bubble_stage}, {5'b00011, 5'b00100, 5'b01000}, exp_vec);
        end
        n_cmp++;
        advance();
        drive('0, 1'b0, 0, 0, 1'b0, 0);
        repeat (3) advance();
    endtask

    task automatic test_reset_mid_timed();
        drive('0, 1'b1, 1, 5, 1'b0, 0);
        advance();
        drive('0, 1'b0, 0, 0, 1'b0, 0);
        advance();
        #2;
        reset_n = 1'b0;
        #1;
        if (obs_vec !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_timed: got %b expected %b", obs_vec, {(3*N+3){1'b0}});
        end
        n_cmp++;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        drive('0, 1'b1, 0, 0, 1'b0, 0);
        #1;
        model_outputs();
        if (timed_ack !== 1'b1 || obs_vec !== exp_vec) begin
            n_fail++;
            $display("[TB] FAIL reset_release: got ack=%b vec=%b expected ack=1 vec=%b", timed_ack, obs_vec, exp_vec);
        end
        n_cmp++;
        advance();
        drive('0, 1'b0, 0, 0, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            settle();
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL after_reset cycle %0d: got %b expected %b", cyc, obs_vec, exp_vec);
            end
            n_cmp++;
            advance();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 2) == 0) ? N'($urandom) : '0,
                  1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 6)), 1'($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 7)));
            settle();
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL random cycle %0d: got %b expected %b", cyc, obs_vec, exp_vec);
            end
            n_cmp++;
            advance();
        end
`ifdef HAZARD_PERF_CNT_EN
        if (stall_cycle_cnt !== 32'(m_stall_cycles) || flush_cnt !== 32'(m_flushes) ||
            timed_abort_cnt !== 32'(m_aborts)) begin
            n_fail++;
            $display("[TB] FAIL perf_counters: got %0d/%0d/%0d expected %0d/%0d/%0d",
                     stall_cycle_cnt, flush_cnt, timed_abort_cnt, m_stall_cycles, m_flushes, m_aborts);
        end
        n_cmp++;
`endif
    endtask

    // Runs the scenarios in order and then prints the summary.
    initial begin
        test_reset();
        test_level_stall();
        test_timed();
        test_flush_abort();
        test_flush_hold();
        test_flush_vs_stall();
        test_reset_mid_timed();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
